// File: rtl/nes_poll_scheduler.sv
// Polls both NES pads back-to-back (left then right) once per poll tick through one
// shared phase counter, and commits both button bytes plus press edges atomically.
module nes_poll_scheduler #(
    parameter int unsigned HALF_T   = 152,
    parameter int unsigned POLL_DIV = 419583
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       nes_data_l,
    input  logic       nes_data_r,
    output logic       nes_latch_l,
    output logic       nes_clk_l,
    output logic       nes_latch_r,
    output logic       nes_clk_r,
    output logic [7:0] buttons_l,
    output logic [7:0] buttons_r,
    output logic [7:0] press_l,
    output logic [7:0] press_r,
    output logic       buttons_valid,
    output logic       busy
);

    localparam int unsigned   TW         = $clog2(POLL_DIV);
    localparam int unsigned   PW         = $clog2(2 * HALF_T);
    localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_DIV - 1);
    localparam logic [PW-1:0] LATCH_LAST = PW'(2 * HALF_T - 1);
    localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_T - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LOW,
        S_HIGH,
        S_COMMIT
    } state_t;

    state_t        state_q;
    logic [TW-1:0] timer_q, timer_d;
    logic          pending_q, pending_d;
    logic          tick;
    logic          leave_idle;
    logic          sel_r_q;
    logic [PW-1:0] phase_q;
    logic [2:0]    bit_q;
    logic [7:0]    shadow_l_q, shadow_r_q;
    logic          latch_l_q, clk_l_q, latch_r_q, clk_r_q;
    logic [7:0]    buttons_l_q, buttons_r_q, press_l_q, press_r_q;
    logic          valid_q, busy_q;
    logic          sample;
    logic [7:0]    commit_r;

    assign tick       = (timer_q == TIMER_LAST);
    assign leave_idle = (state_q == S_IDLE) && pending_q;
    assign sample     = sel_r_q ? ~nes_data_r : ~nes_data_l;
    // Right bit 7 is sampled on the same edge that commits, so it bypasses the shadow.
    assign commit_r   = {~nes_data_r, shadow_r_q[6:0]};

    always_comb begin
        timer_d   = tick ? '0 : timer_q + TW'(1);
        pending_d = pending_q;
        if (leave_idle) pending_d = 1'b0;
        if (tick)       pending_d = 1'b1;
        if (!enable)    pending_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timer_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            sel_r_q     <= 1'b0;
            phase_q     <= '0;
            bit_q       <= '0;
            shadow_l_q  <= '0;
            shadow_r_q  <= '0;
            latch_l_q   <= 1'b0;
            clk_l_q     <= 1'b0;
            latch_r_q   <= 1'b0;
            clk_r_q     <= 1'b0;
            buttons_l_q <= '0;
            buttons_r_q <= '0;
            press_l_q   <= '0;
            press_r_q   <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pending_q) begin
                        state_q   <= S_LATCH;
                        sel_r_q   <= 1'b0;
                        phase_q   <= '0;
                        latch_l_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_LATCH: begin
                    if (phase_q == LATCH_LAST) begin
                        phase_q   <= '0;
                        bit_q     <= '0;
                        latch_l_q <= 1'b0;
                        latch_r_q <= 1'b0;
                        state_q   <= S_LOW;
                    end else begin
                        phase_q <= phase_q + PW'(1);
                    end
                end
                S_LOW: begin
                    if (phase_q == HALF_LAST) begin
                        phase_q <= '0;
                        if (sel_r_q) shadow_r_q[bit_q] <= sample;
                        else         shadow_l_q[bit_q] <= sample;
                        if (bit_q != 3'd7) begin
                            clk_l_q <= ~sel_r_q;
                            clk_r_q <= sel_r_q;
                            state_q <= S_HIGH;
                        end else if (!sel_r_q) begin
                            sel_r_q   <= 1'b1;
                            latch_r_q <= 1'b1;
                            state_q   <= S_LATCH;
                        end else begin
                            buttons_l_q <= shadow_l_q;
                            buttons_r_q <= commit_r;
                            press_l_q   <= shadow_l_q & ~buttons_l_q;
                            press_r_q   <= commit_r & ~buttons_r_q;
                            valid_q     <= 1'b1;
                            state_q     <= S_COMMIT;
                        end
                    end else begin
                        phase_q <= phase_q + PW'(1);
                    end
                end
                S_HIGH: begin
                    if (phase_q == HALF_LAST) begin
                        phase_q <= '0;
                        bit_q   <= bit_q + 3'd1;
                        clk_l_q <= 1'b0;
                        clk_r_q <= 1'b0;
                        state_q <= S_LOW;
                    end else begin
                        phase_q <= phase_q + PW'(1);
                    end
                end
                S_COMMIT: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    latch_l_q <= 1'b0;
                    clk_l_q   <= 1'b0;
                    latch_r_q <= 1'b0;
                    clk_r_q   <= 1'b0;
                end
            endcase
        end
    end

    assign nes_latch_l   = latch_l_q;
    assign nes_clk_l     = clk_l_q;
    assign nes_latch_r   = latch_r_q;
    assign nes_clk_r     = clk_r_q;
    assign buttons_l     = buttons_l_q;
    assign buttons_r     = buttons_r_q;
    assign press_l       = press_l_q;
    assign press_r       = press_r_q;
    assign buttons_valid = valid_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_nes_poll_scheduler.sv
// Bench for nes_poll_scheduler: shift-register pad models, table-driven frames,
// plus hand sequences for mid-frame reset and enable drop.
module tb_nes_poll_scheduler;

    localparam int unsigned HT = 4;
    localparam int unsigned PD = 200;

    logic       clk = 1'b0;
    logic       reset_n, enable, nes_data_l, nes_data_r;
    logic       nes_latch_l, nes_clk_l, nes_latch_r, nes_clk_r;
    logic [7:0] buttons_l, buttons_r, press_l, press_r;
    logic       buttons_valid, busy;

    nes_poll_scheduler #(.HALF_T(HT), .POLL_DIV(PD)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .nes_data_l(nes_data_l), .nes_data_r(nes_data_r),
        .nes_latch_l(nes_latch_l), .nes_clk_l(nes_clk_l),
        .nes_latch_r(nes_latch_r), .nes_clk_r(nes_clk_r),
        .buttons_l(buttons_l), .buttons_r(buttons_r),
        .press_l(press_l), .press_r(press_r),
        .buttons_valid(buttons_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pad_l, pad_r, exp_bl, exp_br, exp_pl, exp_pr;
    } vec_t;

    vec_t vecs[6];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;

    // Pad models: 4021-style shift register, active-low serial output.
    logic [7:0] pad_l = '0, pad_r = '0;
    logic [7:0] sr_l, sr_r;
    bit         pm_cl = 0, pm_cr = 0;
    always @(posedge clk) begin
        sr_l  <= nes_latch_l ? pad_l : (nes_clk_l && !pm_cl) ? {1'b0, sr_l[7:1]} : sr_l;
        sr_r  <= nes_latch_r ? pad_r : (nes_clk_r && !pm_cr) ? {1'b0, sr_r[7:1]} : sr_r;
        pm_cl <= nes_clk_l;
        pm_cr <= nes_clk_r;
    end
    assign nes_data_l = ~sr_l[0];
    assign nes_data_r = ~sr_r[0];

    always @(posedge clk) cyc <= reset_n ? cyc + 1 : 0;

    // Per-frame waveform statistics, restarted on each left latch rise.
    bit pv_ll = 0, pv_lr = 0, pv_cl = 0, pv_cr = 0;
    int lat_l_n, lat_r_n, hi_l, hi_r, pul_l, pul_r, run_l, run_r;
    int bad_run, overlap, busy_n, pul_l_at_r, lat_rises = 0, valid_tot = 0;
    logic fs, bad_l, bad_r;
    assign fs    = nes_latch_l && !pv_ll;
    assign bad_l = !nes_clk_l && pv_cl && (run_l != 4);
    assign bad_r = !nes_clk_r && pv_cr && (run_r != 4);

    always @(negedge clk) begin
        lat_l_n   <= fs ? 1 : lat_l_n + int'(nes_latch_l);
        lat_r_n   <= fs ? 0 : lat_r_n + int'(nes_latch_r);
        hi_l      <= fs ? 0 : hi_l + int'(nes_clk_l);
        hi_r      <= fs ? 0 : hi_r + int'(nes_clk_r);
        pul_l     <= fs ? 0 : pul_l + int'(nes_clk_l && !pv_cl);
        pul_r     <= fs ? 0 : pul_r + int'(nes_clk_r && !pv_cr);
        run_l     <= nes_clk_l ? run_l + 1 : 0;
        run_r     <= nes_clk_r ? run_r + 1 : 0;
        bad_run   <= fs ? 0 : bad_run + int'(bad_l) + int'(bad_r);
        overlap   <= fs ? 0 : overlap + int'((nes_latch_l || nes_clk_l) && (nes_latch_r || nes_clk_r));
        busy_n    <= fs ? 1 : busy_n + int'(busy);
        if (nes_latch_r && !pv_lr) pul_l_at_r <= pul_l;
        lat_rises <= lat_rises + int'(fs);
        valid_tot <= valid_tot + int'(buttons_valid);
        pv_ll <= nes_latch_l;
        pv_lr <= nes_latch_r;
        pv_cl <= nes_clk_l;
        pv_cr <= nes_clk_r;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int bound, output bit got);
        got = 0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (buttons_valid === 1'b1) begin
                got = 1;
                break;
            end
        end
    endtask

    task automatic check_frame(input int idx, input int exp_cyc, input vec_t v, input bit got);
        check($sformatf("f%0d_valid_seen", idx), 64'(got), 64'd1);
        if (got) begin
            #1;
            check($sformatf("f%0d_valid_cycle", idx), 64'(cyc), 64'(exp_cyc));
            check($sformatf("f%0d_buttons_l", idx), 64'(buttons_l), 64'(v.exp_bl));
            check($sformatf("f%0d_buttons_r", idx), 64'(buttons_r), 64'(v.exp_br));
            check($sformatf("f%0d_press_l", idx), 64'(press_l), 64'(v.exp_pl));
            check($sformatf("f%0d_press_r", idx), 64'(press_r), 64'(v.exp_pr));
            check($sformatf("f%0d_latch_l_cycles", idx), 64'(lat_l_n), 64'(2 * HT));
            check($sformatf("f%0d_latch_r_cycles", idx), 64'(lat_r_n), 64'(2 * HT));
            check($sformatf("f%0d_pulses_l", idx), 64'(pul_l), 64'd7);
            check($sformatf("f%0d_pulses_r", idx), 64'(pul_r), 64'd7);
            check($sformatf("f%0d_clk_high_l", idx), 64'(hi_l), 64'(7 * HT));
            check($sformatf("f%0d_clk_high_r", idx), 64'(hi_r), 64'(7 * HT));
            check($sformatf("f%0d_bad_pulse_width", idx), 64'(bad_run), 64'd0);
            check($sformatf("f%0d_pad_overlap", idx), 64'(overlap), 64'd0);
            check($sformatf("f%0d_left_done_at_r_latch", idx), 64'(pul_l_at_r), 64'd7);
            check($sformatf("f%0d_busy_cycles", idx), 64'(busy_n), 64'(34 * HT + 1));
            @(negedge clk);
            check($sformatf("f%0d_valid_one_cycle", idx), 64'(buttons_valid), 64'd0);
            check($sformatf("f%0d_idle_after", idx), 64'(busy), 64'd0);
        end
    endtask

    initial begin
        bit got, found;
        int nz;

        vecs[0] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00};
        vecs[1] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{8'h01, 8'h18, 8'h01, 8'h18, 8'h00, 8'h18};
        vecs[3] = '{8'hA5, 8'h18, 8'hA5, 8'h18, 8'hA4, 8'h00};
        vecs[4] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hE7};
        vecs[5] = '{8'h5A, 8'h81, 8'h5A, 8'h81, 8'h5A, 8'h00};

        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_outputs_zero",
              64'({nes_latch_l, nes_clk_l, nes_latch_r, nes_clk_r, buttons_l, buttons_r,
                   press_l, press_r, buttons_valid, busy}), 64'd0);
        pad_l   = vecs[0].pad_l;
        pad_r   = vecs[0].pad_r;
        reset_n = 1'b1;
        enable  = 1'b1;

        for (int i = 0; i < 6; i++) begin
            pad_l = vecs[i].pad_l;
            pad_r = vecs[i].pad_r;
            wait_valid(400, got);
            check_frame(i, 337 + 200 * i, vecs[i], got);
        end

        // Reset while the right pad clock is high: abort, no commit, clean restart.
        pad_l = 8'hFF;
        pad_r = 8'hFF;
        found = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (nes_clk_r === 1'b1) begin
                found = 1;
                break;
            end
        end
        check("rst_mid_reached_right_high", 64'(found), 64'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_outputs_zero",
              64'({nes_latch_l, nes_clk_l, nes_latch_r, nes_clk_r, buttons_l, buttons_r,
                   press_l, press_r, buttons_valid, busy}), 64'd0);
        pad_l = 8'h22;
        pad_r = 8'h44;
        @(negedge clk);
        reset_n = 1'b1;
        nz  = 0;
        got = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (buttons_valid === 1'b1) begin
                got = 1;
                break;
            end
            if (buttons_l !== 8'h00 || buttons_r !== 8'h00) nz++;
        end
        check("rst_buttons_held_zero", 64'(nz), 64'd0);
        check_frame(6, 337, '{8'h22, 8'h44, 8'h22, 8'h44, 8'h22, 8'h44}, got);

        // Drop enable at the frame mid-point: that frame still commits, then silence.
        found = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (nes_latch_r === 1'b1) begin
                found = 1;
                break;
            end
        end
        check("en_reached_mid", 64'(found), 64'd1);
        enable = 1'b0;
        wait_valid(400, got);
        check_frame(7, 537, '{8'h22, 8'h44, 8'h22, 8'h44, 8'h00, 8'h00}, got);
        repeat (3 * PD + 50) @(negedge clk);
        #1;
        check("en_off_latch_rises_total", 64'(lat_rises), 64'd9);
        check("en_off_valid_total", 64'(valid_tot), 64'd8);
        check("en_off_idle", 64'({busy, nes_latch_l, nes_latch_r}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
